// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and constants for the packet round-robin scheduler.
package pkt_pkg;
   localparam int PLEN_WIDTH     = 14;
   localparam int MAX_DATA_WIDTH = 512;
   typedef enum logic {IDLE, XFER} state_e;
   typedef struct packed {
      logic                      sop;
      logic                      eop;
      logic                      bad;
      logic [PLEN_WIDTH-1:0]     plen;
      logic [MAX_DATA_WIDTH-1:0] data;
   } beat_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic          grant_valid,
   output logic [IW-1:0] grant
);
   logic [IW-1:0] idx;
   // Scan farthest-first so the nearest requester after last_grant overrides.
   always_comb begin
      grant_valid = |req;
      grant = '0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = IW'((int'(last_grant) + i) % N);
         if (req[idx]) grant = idx;
      end
   end
endmodule

// File: rtl/pkt_rr_scheduler.sv
// pkt_rr_scheduler: merges per-port packet streams onto one output, packet-atomic round robin.
module pkt_rr_scheduler
   import pkt_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                  iclk,
   input  logic                                  irst_n,
   input  logic [NUM_PORTS-1:0]                  ivalid,
   input  logic [NUM_PORTS-1:0]                  isop,
   input  logic [NUM_PORTS-1:0]                  ieop,
   input  logic [NUM_PORTS-1:0][PLEN_WIDTH-1:0]  iplen,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  idata,
   input  logic [NUM_PORTS-1:0]                  ibad,
   output logic [NUM_PORTS-1:0]                  iready,
   output logic                                  ovalid,
   output logic                                  osop,
   output logic                                  oeop,
   output logic [PLEN_WIDTH-1:0]                 oplen,
   output logic [DATA_WIDTH-1:0]                 odata,
   output logic                                  obad,
   output logic [$clog2(NUM_PORTS)-1:0]          oport,
   input  logic                                  oready,
   output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]   opkt_cnt,
   output logic                                  ocpu_interrupt
);
   localparam int PW = $clog2(NUM_PORTS);

   state_e                              state_q, state_d;
   logic [PW-1:0]                       grant_q, grant_d, last_q, last_d, port_q, port_d, arb_idx;
   logic                                arb_valid, first_q, first_d, ovalid_q, ovalid_d, irq_q, irq_d;
   logic                                beat_rdy, accept, consume, err_a, err_b, err_c;
   beat_t                               beat_q, beat_d;
   logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .req         (ivalid & isop),
      .last_grant  (last_q),
      .grant_valid (arb_valid),
      .grant       (arb_idx)
   );

   assign beat_rdy = ~ovalid_q | oready;
   assign accept   = (state_q == XFER) && ivalid[grant_q] && beat_rdy;
   assign consume  = ovalid_q & oready;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= PW'(NUM_PORTS - 1);
         port_q   <= '0;
         first_q  <= 1'b0;
         ovalid_q <= 1'b0;
         irq_q    <= 1'b0;
         beat_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         port_q   <= port_d;
         first_q  <= first_d;
         ovalid_q <= ovalid_d;
         irq_q    <= irq_d;
         beat_q   <= beat_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      if (state_q == IDLE && arb_valid) begin
         state_d = XFER;
         grant_d = arb_idx;
         last_d  = arb_idx;
      end else if (accept && ieop[grant_q]) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      iready = '0;
      if (state_q == XFER) iready[grant_q] = beat_rdy;
   end

   assign err_a = accept & ~first_q & isop[grant_q];
   assign err_b = (state_q == IDLE) && |(ivalid & ~isop);
   assign err_c = accept && isop[grant_q] && (iplen[grant_q] == '0);

   // plen/bad are captured only on the packet's first beat so they persist to EOP.
   always_comb begin
      first_d  = (state_q == IDLE) ? 1'b1 : (accept ? 1'b0 : first_q);
      ovalid_d = accept | (ovalid_q & ~oready);
      port_d   = accept ? grant_q : port_q;
      irq_d    = irq_q | err_a | err_b | err_c;
      beat_d   = beat_q;
      if (accept) begin
         beat_d.sop  = isop[grant_q];
         beat_d.eop  = ieop[grant_q];
         beat_d.data = MAX_DATA_WIDTH'(idata[grant_q]);
         if (first_q) begin
            beat_d.plen = iplen[grant_q];
            beat_d.bad  = ibad[grant_q];
         end
      end
      for (int p = 0; p < NUM_PORTS; p++)
         cnt_d[p] = cnt_q[p] + CNT_WIDTH'(consume && beat_q.eop && port_q == PW'(p));
   end

   assign ovalid         = ovalid_q;
   assign osop           = ovalid_q & beat_q.sop;
   assign oeop           = ovalid_q & beat_q.eop;
   assign obad           = ovalid_q & beat_q.bad;
   assign oplen          = ovalid_q ? beat_q.plen : '0;
   assign odata          = beat_q.data[DATA_WIDTH-1:0];
   assign oport          = port_q;
   assign opkt_cnt       = cnt_q;
   assign ocpu_interrupt = irq_q;
endmodule

// File: doc/pkt_rr_scheduler.md
PKT_RR_SCHEDULER -- requirements
Module: pkt_rr_scheduler

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of upstream packet sources (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, beat data width.
REQ-003 Parameter CNT_WIDTH, default 16, per-port packet counter width.
REQ-004 Ports SHALL be exactly as follows.
- iclk  input  1  sole clock; all logic on rising edge.
- irst_n  input  1  reset; asynchronous assert, active-low.
- ivalid  input  NUM_PORTS  per-port beat valid.
- isop  input  NUM_PORTS  per-port start of packet.
- ieop  input  NUM_PORTS  per-port end of packet.
- iplen  input  NUM_PORTS x 14  per-port packet byte length; meaningful on the SOP beat.
- idata  input  NUM_PORTS x DATA_WIDTH  per-port beat data.
- ibad  input  NUM_PORTS  per-port bad-packet flag; meaningful on the SOP beat.
- iready  output  NUM_PORTS  per-port beat accept.
- ovalid  output  1  merged beat valid.
- osop  output  1  merged start of packet.
- oeop  output  1  merged end of packet.
- oplen  output  14  packet length; valid with osop.
- odata  output  DATA_WIDTH  merged beat data.
- obad  output  1  bad flag; valid with osop.
- oport  output  clog2(NUM_PORTS)  source port of the current beat.
- oready  input  1  downstream accept.
- opkt_cnt  output  NUM_PORTS x CNT_WIDTH  per-port count of forwarded packets.
- ocpu_interrupt  output  1  sticky protocol error.

Function
REQ-005 Beat transfer: an input beat SHALL be accepted when ivalid[p] and iready[p] are both high; an output beat SHALL be consumed when ovalid and oready are both high.
REQ-006 State machine states: IDLE and XFER.
REQ-007 IDLE: the block SHALL form a request vector req[p] = ivalid[p] & isop[p], and SHALL grant the first requesting port after last_grant in ascending circular order.
REQ-008 On a grant, the block SHALL register grant and last_grant and SHALL move to XFER on the next cycle. No beat is accepted in IDLE, so each packet costs exactly 1 arbitration cycle.
REQ-009 In IDLE with no request, the block SHALL stay in IDLE and hold last_grant.
REQ-010 In XFER, iready[grant] SHALL equal (~ovalid | oready). All other iready bits SHALL be 0.
REQ-011 An accepted beat SHALL load the output register, so it appears on the outputs exactly 1 cycle later.
- Register contents: sop, eop, data, plen, bad, port.
- Outputs SHALL hold stable while ovalid & ~oready.
REQ-012 When no beat is accepted and the output register is consumed (or already empty), ovalid SHALL be 0 on the next cycle.
REQ-013 Acceptance of the granted port's ieop beat SHALL return the FSM to IDLE on the next cycle.
REQ-014 A single-beat packet (isop & ieop on the same beat) SHALL be legal.
REQ-015 osop, oeop, obad and oplen SHALL be qualified by ovalid. oplen and obad SHALL hold their SOP-beat values for the whole packet.
REQ-016 opkt_cnt[p] SHALL increment by 1 on each output beat consumed with oeop and oport==p, and SHALL wrap modulo 2^CNT_WIDTH.
REQ-017 Protocol errors SHALL set a sticky ocpu_interrupt, cleared only by reset. The errors are:
- (a) an accepted non-first beat in XFER with isop high;
- (b) in IDLE, ivalid[p] high with isop[p] low on any port;
- (c) an accepted SOP beat with iplen == 0.
REQ-018 A beat that raises an error SHALL still be forwarded unchanged. The block SHALL never drop or reorder beats.
REQ-019 Ports not granted SHALL be backpressured indefinitely, with no timeout.

Reset
REQ-020 While irst_n is low, every register SHALL be cleared asynchronously:
- state=IDLE, ovalid=0, osop=0, oeop=0, obad=0, oplen=0, odata=0, oport=0;
- opkt_cnt=0, ocpu_interrupt=0, iready=0;
- last_grant=NUM_PORTS-1, so port 0 wins first.
REQ-021 Reset asserted mid-packet SHALL discard the packet in flight. After deassertion, arbitration SHALL restart from IDLE.

Structure
REQ-022 Package pkt_pkg SHALL hold: the beat struct (sop, eop, bad, plen[13:0], data), the FSM state enum, and the PLEN_WIDTH=14 constant.
REQ-023 Round-robin grant selection SHALL live in a sub-module rr_arbiter:
- parameter N;
- inputs req and last_grant;
- outputs grant_valid and grant index;
- purely combinational.

Verification
REQ-024 Ports 0 and 2 each present a 3-beat packet at once after reset -> port 0 forwarded first, then port 2. Each packet is preceded by 1 IDLE cycle. opkt_cnt[0]=opkt_cnt[2]=1.
REQ-025 All 4 ports continuously request single-beat packets, oready=1 -> output port order 0,1,2,3,0,1,... and ovalid toggles 1,0,1,0.
REQ-026 oready held low for 5 cycles mid-packet -> odata stable and iready[grant]=0 throughout. No beat is lost or duplicated when oready returns high.
REQ-027 Packet with iplen=100, ibad=1 on port 1 -> oplen=100 and obad=1 on the osop beat, held until oeop. ocpu_interrupt stays 0.
REQ-028 Port 3 asserts ivalid without isop in IDLE -> ocpu_interrupt=1 next cycle and stays 1. irst_n pulse mid-packet -> all outputs 0 and the next grant goes to port 0.
